config_loader: RTL

- Configuration sequencer for the logic-element fabric.
- Accepts the bitstream as parallel words over a valid/ready handshake and serialises them, LSB first, into the fabric's configuration scan chain. The chain carries the per-element LUT truth table and the comb/seq output select.
- Holds the fabric's register enable low until the full chain has been loaded.
- Sits between the host/bitstream source and the top-level fabric instance.

---
 rtl/config_pkg.sv | 29 ++
 rtl/word_serializer.sv | 61 ++++++
 rtl/config_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// Shared definitions for the fabric configuration loader: the sequencer
// state encoding and the layout of one logic element's configuration slice.
package config_pkg;

  // Loader sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One logic element contributes a 4-bit LUT truth table plus a
  // comb/seq output-select bit to the scan chain.
  localparam int LE_CONFIG_WIDTH = 5;
  localparam int LE_LUT_LSB      = 0;
  localparam int LE_LUT_MSB      = 3;
  localparam int LE_COMB_SEL_BIT = 4;

  // Default fabric size: 16 elements, giving an 80-bit chain.
  localparam int LE_DEFAULT_COUNT       = 16;
  localparam int LE_DEFAULT_CHAIN_WIDTH = LE_DEFAULT_COUNT * LE_CONFIG_WIDTH;

  // Number of bitstream words needed to fill a chain of cw bits.
  function automatic int words_per_load(input int cw, input int ww);
    return (cw + ww - 1) / ww;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial stage: captures one bitstream word and presents it
// LSB first, tracking the position inside the word so the sequencer knows
// when the word has been fully consumed.
module word_serializer
  import config_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  output logic                  serial_o,
  output logic                  last_bit_o
);

  localparam int PW = $clog2(WORD_WIDTH + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(WORD_WIDTH - 1);

  logic [WORD_WIDTH-1:0] sreg_q, sreg_d;
  logic [WORD_WIDTH-1:0] sreg_shifted;
  logic [PW-1:0]         word_pos_q, word_pos_d;

  // Right-shift network: each bit takes its upper neighbour, top bit fills with 0
  for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_shift
    if (gi == WORD_WIDTH - 1) begin : g_top
      assign sreg_shifted[gi] = 1'b0;
    end else begin : g_mid
      assign sreg_shifted[gi] = sreg_q[gi+1];
    end
  end

  // Next-state for the word register and bit position (load wins over shift)
  always_comb begin
    sreg_d     = sreg_q;
    word_pos_d = word_pos_q;
    if (load_i) begin
      sreg_d     = word_i;
      word_pos_d = '0;
    end else if (shift_i) begin
      sreg_d     = sreg_shifted;
      word_pos_d = word_pos_q + PW'(1);
    end
  end

  // Word register and position counter with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!nreset) begin
      sreg_q     <= '0;
      word_pos_q <= '0;
    end else begin
      sreg_q     <= sreg_d;
      word_pos_q <= word_pos_d;
    end
  end

  assign serial_o   = sreg_q[0];
  assign last_bit_o = (word_pos_q == POS_LAST);

endmodule

// File: rtl/config_loader.sv
// Configuration sequencer for the logic-element fabric. Takes the bitstream
// as words over a valid/ready handshake, streams them LSB first into the
// configuration scan chain, and only releases the fabric register enable
// once every chain bit has been shifted in.
module config_loader
  import config_pkg::*;
#(
  parameter int CONFIG_WIDTH = LE_DEFAULT_CHAIN_WIDTH,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_ready,
  output logic                  config_shift,
  output logic                  config_bit,
  output logic                  fabric_enable,
  output logic                  done,
  output logic                  busy
);

  localparam int BW = $clog2(CONFIG_WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CONFIG_WIDTH - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] bit_count_q, bit_count_d;

  logic ser_load;
  logic ser_shift;
  logic ser_bit;
  logic word_last;
  logic chain_last;

  // A word is only captured when the handshake completes and no abort is
  // cancelling the load in the same cycle.
  assign ser_load   = (state_q == LOAD) && word_valid && !abort;
  assign ser_shift  = (state_q == SHIFT);
  assign chain_last = (bit_count_q == BIT_LAST);

  word_serializer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_word_serializer (
    .clock     (clock),
    .nreset    (nreset),
    .load_i    (ser_load),
    .shift_i   (ser_shift),
    .word_i    (word_data),
    .serial_o  (ser_bit),
    .last_bit_o(word_last)
  );

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: abort beats handshake and shift exit; the chain-full
  // exit beats the word-consumed exit so a partial last word is truncated.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (abort)           state_d = IDLE;
        else if (word_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort)           state_d = IDLE;
        else if (chain_last) state_d = DONE;
        else if (word_last)  state_d = LOAD;
      end
      DONE: begin
        if (start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Chain bit counter: cleared when a load begins, advanced per shift cycle
  always_comb begin
    bit_count_d = bit_count_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) bit_count_d = '0;
      end
      SHIFT: begin
        bit_count_d = bit_count_q + BW'(1);
      end
      default: ;
    endcase
  end

  // Chain bit counter register
  always_ff @(posedge clock) begin
    if (!nreset) begin
      bit_count_q <= '0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  // Output decode from the current state; config_bit is forced low outside SHIFT
  always_comb begin
    word_ready    = 1'b0;
    config_shift  = 1'b0;
    fabric_enable = 1'b0;
    done          = 1'b0;
    busy          = 1'b0;
    case (state_q)
      LOAD: begin
        busy       = 1'b1;
        word_ready = 1'b1;
      end
      SHIFT: begin
        busy         = 1'b1;
        config_shift = 1'b1;
      end
      DONE: begin
        done          = 1'b1;
        fabric_enable = 1'b1;
      end
      default: ;
    endcase
    config_bit = config_shift & ser_bit;
  end

endmodule
